memory_cycle: RTL and testbench

MEMORY_CYCLE -- requirements
Module: memory_cycle

---
 rtl/memory_cycle.sv | 164 ++++++++++++++++
 tb/tb_memory_cycle.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_cycle.sv
// MEM stage of a 5-stage RV32 pipeline: byte-addressable data memory plus the MEM/WB register.
// Optional macro MISALIGN_TRAP_EN adds misaligned-access detection and the MisalignW output.
module memory_cycle #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        JumpM,
  input  logic        StallW,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  WriteReg_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        JumpW,
  output logic [4:0]  WriteReg_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        MisalignW
`endif
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]   mem [DMEM_WORDS];
  logic [AW-1:0] idx_p0;
  logic [1:0]    lane_p0;
  logic [31:0]   rd_word_p0;
  logic [31:0]   ld_data_p0;
  logic [31:0]   wr_word_p0;
  logic          we_p0;
  logic          mis_ld_p0;
  logic          mis_st_p0;
  logic          unused_addr_bits;

  // Little-endian lane extraction with sign/zero extension; undefined funct3 codes read a full word.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bs;
    logic signed [31:0] hs;
    logic [31:0]        r;
    b  = w[{lane, 3'b000} +: 8];
    h  = lane[1] ? w[31:16] : w[15:0];
    bs = b;
    hs = h;
    case (f3)
      3'd0:    r = bs;
      3'd1:    r = hs;
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Read-modify-write merge: only the addressed byte/half lanes take new data.
  function automatic logic [31:0] store_merge(input logic [31:0] old_w, input logic [31:0] data,
                                              input logic [1:0] lane, input logic [2:0] f3);
    logic [3:0]  be;
    logic [31:0] wdat;
    logic [31:0] r;
    case (f3)
      3'd0: begin
        be   = 4'b0001 << lane;
        wdat = {4{data[7:0]}};
      end
      3'd1: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wdat = {2{data[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wdat = data;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? wdat[8*i +: 8] : old_w[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic ld_misaligned(input logic [1:0] lane, input logic [2:0] f3);
    logic r;
    case (f3[1:0])
      2'b00:   r = 1'b0;
      2'b01:   r = lane[0];
      default: r = (lane != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic st_misaligned(input logic [1:0] lane, input logic [2:0] f3);
    logic r;
    case (f3)
      3'd0:    r = 1'b0;
      3'd1:    r = lane[0];
      default: r = (lane != 2'b00);
    endcase
    return r;
  endfunction

  // ---- p0: MEM stage, combinational address decode, read and store merge ----
  assign idx_p0           = ALU_ResultM[AW+1:2];
  assign lane_p0          = ALU_ResultM[1:0];
  assign unused_addr_bits = ^ALU_ResultM[31:AW+2];
  assign rd_word_p0       = mem[idx_p0];
  assign ld_data_p0       = load_extract(rd_word_p0, lane_p0, funct3M);
  assign wr_word_p0       = store_merge(rd_word_p0, WriteDataM, lane_p0, funct3M);

`ifdef MISALIGN_TRAP_EN
  assign mis_ld_p0 = MemtoRegM & ld_misaligned(lane_p0, funct3M);
  assign mis_st_p0 = MemWriteM & st_misaligned(lane_p0, funct3M);
`else
  assign mis_ld_p0 = 1'b0;
  assign mis_st_p0 = 1'b0;
`endif

  // Commit happens on this edge, so a load issued next cycle already sees the new word.
  assign we_p0 = MemWriteM & ~StallW & ~rst & ~mis_st_p0;

  always_ff @(posedge clk) begin
    if (we_p0) begin
      mem[idx_p0] <= wr_word_p0;
    end
  end

  // ---- p1: MEM/WB register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW   <= 1'b0;
      MemtoRegW   <= 1'b0;
      JumpW       <= 1'b0;
      WriteReg_W  <= 5'd0;
      PCPlus4W    <= 32'd0;
      ALU_ResultW <= 32'd0;
      ReadDataW   <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      MisalignW   <= 1'b0;
`endif
    end else if (!StallW) begin
      RegWriteW   <= RegWriteM & ~mis_ld_p0;
      MemtoRegW   <= MemtoRegM;
      JumpW       <= JumpM;
      WriteReg_W  <= WriteReg_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= mis_ld_p0 ? 32'd0 : ld_data_p0;
`ifdef MISALIGN_TRAP_EN
      MisalignW   <= mis_ld_p0 | mis_st_p0;
`endif
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: byte-array reference model, directed scenarios, then randomized traffic.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, MemtoRegM, JumpM, StallW;
  logic [2:0]  funct3M;
  logic [4:0]  WriteReg_M;
  logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
  logic        RegWriteW, MemtoRegW, JumpW;
  logic [4:0]  WriteReg_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignW;
`endif

  memory_cycle #(.DMEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .JumpM(JumpM),
    .StallW(StallW), .funct3M(funct3M), .WriteReg_M(WriteReg_M),
    .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .JumpW(JumpW), .WriteReg_W(WriteReg_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
`ifdef MISALIGN_TRAP_EN
    , .MisalignW(MisalignW)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: 4 KiB byte-addressed memory and the expected writeback outputs.
  logic [7:0]  bm [4096];
  logic        e_rw, e_m2r, e_j, e_mis;
  logic [4:0]  e_wr;
  logic [31:0] e_pc, e_alu, e_rd;

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
    int a;
    logic [15:0] h;
    logic [31:0] r;
    a = int'(addr[11:0]);
    case (f3)
      3'd0, 3'd4: r = (f3 == 3'd0) ? {{24{bm[a][7]}}, bm[a]} : {24'd0, bm[a]};
      3'd1, 3'd5: begin
        a = a - (a % 2);
        h = {bm[a+1], bm[a]};
        r = (f3 == 3'd1) ? {{16{h[15]}}, h} : {16'd0, h};
      end
      default: begin
        a = a - (a % 4);
        r = {bm[a+3], bm[a+2], bm[a+1], bm[a]};
      end
    endcase
    return r;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] d);
    int a;
    int n;
    a = int'(addr[11:0]);
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    a = a - (a % n);
    for (int i = 0; i < n; i++) bm[a+i] = d[8*i +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".RegWriteW"}, {31'd0, RegWriteW}, {31'd0, e_rw});
    chk({tag, ".MemtoRegW"}, {31'd0, MemtoRegW}, {31'd0, e_m2r});
    chk({tag, ".JumpW"}, {31'd0, JumpW}, {31'd0, e_j});
    chk({tag, ".WriteReg_W"}, {27'd0, WriteReg_W}, {27'd0, e_wr});
    chk({tag, ".PCPlus4W"}, PCPlus4W, e_pc);
    chk({tag, ".ALU_ResultW"}, ALU_ResultW, e_alu);
    chk({tag, ".ReadDataW"}, ReadDataW, e_rd);
`ifdef MISALIGN_TRAP_EN
    chk({tag, ".MisalignW"}, {31'd0, MisalignW}, {31'd0, e_mis});
`endif
  endtask

  // One clock: drive the MEM inputs, predict the writeback state, advance, and compare.
  task automatic step(input string tag, input logic r, input logic st, input logic mw,
                      input logic m2r, input logic [2:0] f3, input logic [31:0] alu,
                      input logic [31:0] wd);
    logic mis_ld, mis_st;
    logic [31:0] pc;
    logic [4:0]  wr;
    logic        rw, j;
    pc = $urandom; wr = 5'($urandom); rw = 1'($urandom); j = 1'($urandom);
    rst = r; StallW = st; MemWriteM = mw; MemtoRegM = m2r; funct3M = f3;
    ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc; WriteReg_M = wr;
    RegWriteM = rw; JumpM = j;
    mis_ld = 1'b0;
    mis_st = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (m2r) begin
      if (f3 == 3'd1 || f3 == 3'd5) mis_ld = (alu % 2) != 0;
      else if (f3 != 3'd0 && f3 != 3'd4) mis_ld = (alu % 4) != 0;
    end
    if (mw) begin
      if (f3 == 3'd1) mis_st = (alu % 2) != 0;
      else if (f3 != 3'd0) mis_st = (alu % 4) != 0;
    end
`endif
    if (r) begin
      e_rw = 0; e_m2r = 0; e_j = 0; e_wr = 0; e_pc = 0; e_alu = 0; e_rd = 0; e_mis = 0;
    end else if (!st) begin
      e_rw  = rw && !mis_ld;
      e_m2r = m2r;
      e_j   = j;
      e_wr  = wr;
      e_pc  = pc;
      e_alu = alu;
      e_rd  = mis_ld ? 32'd0 : model_load(alu, f3);
      e_mis = mis_ld || mis_st;
    end
    if (!r && !st && mw && !mis_st) model_store(alu, f3, wd);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic sto(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    step(tag, 1'b0, 1'b0, 1'b1, 1'b0, f3, a, d);
  endtask

  task automatic lod(input string tag, input logic [2:0] f3, input logic [31:0] a);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b1, f3, a, $urandom);
  endtask

  initial begin
    rst = 1'b1; StallW = 1'b0; MemWriteM = 1'b0; MemtoRegM = 1'b0; RegWriteM = 1'b0;
    JumpM = 1'b0; funct3M = 3'd0; WriteReg_M = 5'd0; PCPlus4M = 0; ALU_ResultM = 0; WriteDataM = 0;

    step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
    chk("reset.ReadDataW_zero", ReadDataW, 32'h0);

    // Give the first 256 bytes known contents so every later read is defined.
    for (int i = 0; i < 64; i++) sto("init", 3'd2, 32'(i * 4), $urandom);

    // Reset with a store presented: outputs clear, store suppressed.
    sto("pre17", 3'd2, 32'h10, 32'h12345678);
    step("rst_store", 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h10, 32'hDEADBEEF);
    lod("ld10", 3'd2, 32'h10);
    chk("ld10.literal", ReadDataW, 32'h12345678);

    sto("sw20", 3'd2, 32'h20, 32'h80FF7F01);
    lod("lb20", 3'd0, 32'h20);  chk("lb20.literal", ReadDataW, 32'h00000001);
    lod("lb23", 3'd0, 32'h23);  chk("lb23.literal", ReadDataW, 32'hFFFFFF80);
    lod("lbu23", 3'd4, 32'h23); chk("lbu23.literal", ReadDataW, 32'h00000080);
    lod("lh22", 3'd1, 32'h22);  chk("lh22.literal", ReadDataW, 32'hFFFF80FF);
    lod("lhu22", 3'd5, 32'h22); chk("lhu22.literal", ReadDataW, 32'h000080FF);

    sto("sw30", 3'd2, 32'h30, 32'h11223344);
    sto("sb31", 3'd0, 32'h31, 32'h000000AA);
    sto("sh32", 3'd1, 32'h32, 32'h0000BBCC);
    lod("lw30", 3'd2, 32'h30);  chk("lw30.literal", ReadDataW, 32'hBBCCAA44);

    sto("sw1004", 3'd2, 32'h1004, 32'h5);
    lod("lw4", 3'd2, 32'h4);    chk("lw4.wrap", ReadDataW, 32'h5);

    sto("pre21", 3'd2, 32'h40, 32'h0);
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 32'h40, 32'h9);
    step("unstall", 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 32'h40, 32'h9);
    lod("lw40", 3'd2, 32'h40);  chk("lw40.literal", ReadDataW, 32'h9);

`ifdef MISALIGN_TRAP_EN
    sto("sw42_mis", 3'd2, 32'h42, 32'h7);
    chk("sw42.MisalignW", {31'd0, MisalignW}, 32'd1);
    lod("lw40_after", 3'd2, 32'h40); chk("lw40_after.literal", ReadDataW, 32'h9);
    lod("lh41_mis", 3'd1, 32'h41);
    chk("lh41.ReadDataW", ReadDataW, 32'h0);
    chk("lh41.RegWriteW", {31'd0, RegWriteW}, 32'd0);
    chk("lh41.MisalignW", {31'd0, MisalignW}, 32'd1);
    lod("lw44", 3'd2, 32'h44);
    chk("lw44.MisalignW", {31'd0, MisalignW}, 32'd0);
`endif

    // Randomized traffic over the initialized region, with random upper address bits.
    for (int i = 0; i < 400; i++) begin
      int kind;
      logic [31:0] a;
      kind = int'($urandom % 3);
      a = ($urandom & 32'hFFFF_F000) | ($urandom % 256);
      step("rand", ($urandom % 40) == 0, ($urandom % 5) == 0, kind == 0, kind == 1,
           3'($urandom), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
